// File: rtl/ztex_host_if.sv
// ztex_host_if
//   Byte-serial host interface for multi-core ZTEX litecoin builds.
//   - Work load: the host presents a byte on `read` and toggles `rd_clk`;
//     IN_BYTES bytes are shifted into a shadow buffer that is copied to
//     `work_data` every cycle. `new_work` pulses once per complete load.
//   - Golden nonces: up to NCORES cores report matches; one per cycle is
//     pushed into a FIFO_DEPTH-entry FIFO, the rest are parked as pending.
//   - Readback: while `wr_start` is high a status/nonce record is snapshot
//     into an output shift register; each `wr_clk` toggle advances it by a
//     byte, presented on the registered `write` output.
//
// Ports
//   clk        mining clock (all logic on posedge)
//   reset      asynchronous active-high reset
//   rd_clk     host write strobe (toggle), asynchronous
//   wr_clk     host read strobe (toggle), asynchronous
//   wr_start   host level: snapshot record while high
//   read       host data byte
//   write      output byte to host (registered)
//   gn_in      golden nonce per core, core k at [32k+31:32k]
//   gn_match   one-cycle match pulse per core
//   nonce_in   current nonce of core 0
//   work_data  work buffer, first received byte at [7:0]
//   new_work   one-cycle pulse after the last byte of a load lands
//
// Build option
//   HOSTIF_CHECKSUM_EN : record byte 9 carries the XOR of bytes 0..8.
//                        Without it byte 9 reads as zero.

module ztex_host_if #(
   parameter int unsigned IN_BYTES   = 84,
   parameter int unsigned NCORES     = 1,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rd_clk,
   input  logic                   wr_clk,
   input  logic                   wr_start,
   input  logic [7:0]             read,
   output logic [7:0]             write,
   input  logic [NCORES*32-1:0]   gn_in,
   input  logic [NCORES-1:0]      gn_match,
   input  logic [31:0]            nonce_in,
   output logic [IN_BYTES*8-1:0]  work_data,
   output logic                   new_work
);

   localparam int unsigned IN_BITS = IN_BYTES * 8;
   localparam int unsigned BW      = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW      = AW + 1;
   localparam int unsigned RB      = 80;  // record buffer: 10 bytes

   // ------------------------------------------------------------------
   // Input sampling and toggle-strobe detection
   // ------------------------------------------------------------------
   logic [7:0] read_buf_q;
   logic       rd_clk_q, wr_clk_q;
   logic [3:0] rd_hist_q, wr_hist_q;
   logic       rd_stb, wr_stb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_buf_q <= '0;
         rd_clk_q   <= 1'b0;
         wr_clk_q   <= 1'b0;
         rd_hist_q  <= '0;
         wr_hist_q  <= '0;
      end else begin
         read_buf_q <= read;
         rd_clk_q   <= rd_clk;
         wr_clk_q   <= wr_clk;
         rd_hist_q  <= {rd_hist_q[2:0], rd_clk_q};
         wr_hist_q  <= {wr_hist_q[2:0], wr_clk_q};
      end
   end

   // Old level must have been stable for three samples before a change counts.
   assign rd_stb = (rd_hist_q[3] == rd_hist_q[2]) && (rd_hist_q[2] == rd_hist_q[1]) &&
                   (rd_hist_q[1] != rd_hist_q[0]);
   assign wr_stb = (wr_hist_q[3] == wr_hist_q[2]) && (wr_hist_q[2] == wr_hist_q[1]) &&
                   (wr_hist_q[1] != wr_hist_q[0]);

   // ------------------------------------------------------------------
   // Work buffer
   // ------------------------------------------------------------------
   logic [IN_BITS-1:0] shadow_q, work_data_q;
   logic [BW-1:0]      byte_cnt_q;
   logic               nw_pipe_q, new_work_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q    <= '0;
         work_data_q <= '0;
         byte_cnt_q  <= '0;
         nw_pipe_q   <= 1'b0;
         new_work_q  <= 1'b0;
      end else begin
         work_data_q <= shadow_q;
         new_work_q  <= nw_pipe_q;
         nw_pipe_q   <= 1'b0;
         if (rd_stb) begin
            shadow_q <= {read_buf_q, shadow_q[IN_BITS-1:8]};
            if (byte_cnt_q == BW'(IN_BYTES - 1)) begin
               byte_cnt_q <= '0;
               nw_pipe_q  <= 1'b1;
            end else begin
               byte_cnt_q <= byte_cnt_q + BW'(1);
            end
         end
      end
   end

   assign work_data = work_data_q;
   assign new_work  = new_work_q;

   // ------------------------------------------------------------------
   // Golden nonce capture
   // ------------------------------------------------------------------
   logic [NCORES-1:0] pending_q, pending_d, req, sel_oh;
   logic [31:0]       hold_q [NCORES];
   logic [31:0]       hold_d [NCORES];
   logic [31:0]       push_data;
   logic              found, drop_match, push, drop;
   logic              full, empty, pop;

   always_comb begin
      req        = gn_match | pending_q;
      sel_oh     = '0;
      found      = 1'b0;
      push_data  = '0;
      pending_d  = pending_q;
      hold_d     = hold_q;
      drop_match = 1'b0;
      for (int unsigned k = 0; k < NCORES; k++) begin
         if (req[k] && !found) begin
            found     = 1'b1;
            sel_oh[k] = 1'b1;
            push_data = pending_q[k] ? hold_q[k] : gn_in[k*32 +: 32];
         end
      end
      for (int unsigned k = 0; k < NCORES; k++) begin
         if (sel_oh[k]) begin
            // A selected pending value goes out first; a same-cycle new
            // match on that core then becomes the next pending value.
            if (pending_q[k] && gn_match[k]) hold_d[k] = gn_in[k*32 +: 32];
            else                             pending_d[k] = 1'b0;
         end else if (gn_match[k]) begin
            if (pending_q[k]) drop_match = 1'b1;
            else begin
               pending_d[k] = 1'b1;
               hold_d[k]    = gn_in[k*32 +: 32];
            end
         end
      end
      push = found && (!full || pop);
      drop = drop_match || (found && !push);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         for (int unsigned k = 0; k < NCORES; k++) hold_q[k] <= '0;
      end else begin
         pending_q <= pending_d;
         hold_q    <= hold_d;
      end
   end

   // ------------------------------------------------------------------
   // Nonce FIFO
   // ------------------------------------------------------------------
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;

   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign empty = (count_q == '0);

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Record snapshot and readback
   // ------------------------------------------------------------------
   logic          ws1_q, ws_q, ws_prev_q, ws_fall;
   logic [3:0]    wr_delay_q;
   logic [RB-1:0] outbuf_q;
   logic [7:0]    write_q;
   logic          overflow_q;
   logic [31:0]   head;
   logic [3:0]    cnt_sat;
   logic [71:0]   rec_lo;
   logic [7:0]    rec_chk;

   assign head    = empty ? 32'h0 : mem_q[rptr_q];
   assign cnt_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
   assign rec_lo  = {~empty, overflow_q, 2'b00, cnt_sat, nonce_in, head};

`ifdef HOSTIF_CHECKSUM_EN
   always_comb begin
      rec_chk = '0;
      for (int unsigned i = 0; i < 9; i++) rec_chk = rec_chk ^ rec_lo[i*8 +: 8];
   end
`else
   assign rec_chk = '0;
`endif

   assign ws_fall = ws_prev_q && !ws_q;
   // outbuf still holds the record the host is reading, so its valid and
   // overflow bits decide what the falling edge acknowledges.
   assign pop     = ws_fall && outbuf_q[71] && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws1_q      <= 1'b0;
         ws_q       <= 1'b0;
         ws_prev_q  <= 1'b0;
         wr_delay_q <= '0;
         outbuf_q   <= '0;
         write_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         ws1_q     <= wr_start;
         ws_q      <= ws1_q;
         ws_prev_q <= ws_q;
         write_q   <= outbuf_q[7:0];
         if (ws_q) begin
            wr_delay_q <= '0;
            outbuf_q   <= {rec_chk, rec_lo};
         end else begin
            wr_delay_q <= {wr_delay_q[2:0], 1'b1};
            if (wr_delay_q[3] && wr_stb) outbuf_q <= {8'h00, outbuf_q[RB-1:8]};
         end
         if (drop)                         overflow_q <= 1'b1;
         else if (ws_fall && outbuf_q[70]) overflow_q <= 1'b0;
      end
   end

   assign write = write_q;

endmodule

// File: tb/tb_ztex_host_if.sv
module tb_ztex_host_if;

   logic         clk, reset, rd_clk, wr_clk, wr_start;
   logic [7:0]   read, write;
   logic [127:0] gn_in;
   logic [3:0]   gn_match;
   logic [31:0]  nonce_in;
   logic [671:0] work_data;
   logic         new_work;

   int errors = 0;
   int checks = 0;
   int nw_cnt = 0;

   ztex_host_if #(.IN_BYTES(84), .NCORES(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .rd_clk(rd_clk), .wr_clk(wr_clk),
      .wr_start(wr_start), .read(read), .write(write), .gn_in(gn_in),
      .gn_match(gn_match), .nonce_in(nonce_in), .work_data(work_data),
      .new_work(new_work)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (new_work === 1'b1) nw_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      read   = b;
      rd_clk = ~rd_clk;
      repeat (5) @(negedge clk);
   endtask

   task automatic poll(input string tag, input logic [31:0] head,
                       input logic [31:0] nonce, input logic [7:0] status);
      logic [7:0] exp_b [11];
      for (int i = 0; i < 4; i++) begin
         exp_b[i]     = head[i*8 +: 8];
         exp_b[4 + i] = nonce[i*8 +: 8];
      end
      exp_b[8]  = status;
      exp_b[9]  = 8'h00;
      exp_b[10] = 8'h00;
`ifdef HOSTIF_CHECKSUM_EN
      for (int i = 0; i < 9; i++) exp_b[9] = exp_b[9] ^ exp_b[i];
`endif
      @(negedge clk);
      nonce_in = nonce;
      wr_start = 1'b1;
      repeat (4) @(negedge clk);
      wr_start = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         check($sformatf("%s_b%0d", tag, i), {24'h0, write}, {24'h0, exp_b[i]});
         wr_clk = ~wr_clk;
         repeat (6) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; rd_clk = 1'b0; wr_clk = 1'b0; wr_start = 1'b0;
      read = '0; gn_in = '0; gn_match = '0; nonce_in = '0;
      repeat (3) @(negedge clk);
      check("rst_write", {24'h0, write}, 32'h0);
      check("rst_new_work", {31'h0, new_work}, 32'h0);
      check("rst_work_lo", work_data[31:0], 32'h0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Empty FIFO record with a live nonce
      poll("empty", 32'h0, 32'h12345678, 8'h00);

      // Full work load 0x01..0x54
      for (int i = 0; i < 84; i++) send_byte(8'(i + 1));
      repeat (4) @(negedge clk);
      check("load_first", {24'h0, work_data[7:0]}, 32'h01);
      check("load_last", {24'h0, work_data[671:664]}, 32'h54);
      check("load_mid", {24'h0, work_data[335:328]}, 32'h2A);
      check("load_nw", nw_cnt, 1);

      // Glitch between clock edges must not shift
      @(negedge clk);
      #1 rd_clk = ~rd_clk;
      #2 rd_clk = ~rd_clk;
      repeat (8) @(negedge clk);
      check("glitch_first", {24'h0, work_data[7:0]}, 32'h01);
      check("glitch_last", {24'h0, work_data[671:664]}, 32'h54);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (4) @(negedge clk);
      check("two_last", {24'h0, work_data[671:664]}, 32'hBB);
      check("two_prev", {24'h0, work_data[663:656]}, 32'hAA);
      check("two_first", {24'h0, work_data[7:0]}, 32'h03);
      check("two_nw", nw_cnt, 1);

      // Simultaneous matches on cores 0, 1, 3
      @(negedge clk);
      gn_in    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      gn_match = 4'b1011;
      @(negedge clk);
      gn_match = 4'b0000;
      gn_in    = '0;
      repeat (4) @(negedge clk);
      poll("multi0", 32'hA0, 32'hCAFEF00D, 8'h83);
      poll("multi1", 32'hA1, 32'hCAFEF00D, 8'h82);
      poll("multi2", 32'hA3, 32'hCAFEF00D, 8'h81);

      // Nine matches into an eight-entry FIFO
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         gn_in[31:0] = 32'h100 + 32'(i);
         gn_match    = 4'b0001;
      end
      @(negedge clk);
      gn_match = 4'b0000;
      repeat (4) @(negedge clk);
      poll("ovf0", 32'h100, 32'h0, 8'hC8);
      poll("ovf1", 32'h101, 32'h0, 8'h87);

      // Reset in the middle of a readback
      @(negedge clk);
      wr_start = 1'b1;
      repeat (4) @(negedge clk);
      wr_start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_b0", {24'h0, write}, 32'h02);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_write", {24'h0, write}, 32'h0);
      check("mid_rst_work", work_data[671:640], 32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      poll("after_rst", 32'h0, 32'h0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
